// File: rtl/axilite_m_arb.sv
// Round-robin arbiter that shares one AXI-Lite master command port among NREQ local requesters,
// with a watchdog that forces an error completion if the master never finishes.
module axilite_m_arb #(
    parameter int NREQ = 4,
    parameter int AW   = 32,
    parameter int DW   = 32,
    parameter int WDOG = 32
) (
    input  logic               m_axi_aclk,
    input  logic               m_axi_areset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    req_wr,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [DW-1:0]      rsp_rdata,
    output logic [1:0]         rsp_resp,
    output logic               rsp_timeout,
    output logic               cmd_new_tx,
    output logic               cmd_wr,
    output logic [AW-1:0]      cmd_waddr,
    output logic [AW-1:0]      cmd_raddr,
    output logic [DW-1:0]      cmd_din,
    input  logic               cmd_done,
    input  logic [DW-1:0]      cmd_dout,
    input  logic [1:0]         cmd_resp,
    input  logic               cmd_timeout
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(WDOG);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] ptr_q;
    logic [IW-1:0] owner_q;
    logic [IW-1:0] sel_idx;
    logic          sel_found;
    logic [CW-1:0] wdog_q;
    logic          wdog_exp;
    logic [AW-1:0] addr_a  [NREQ];
    logic [DW-1:0] wdata_a [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign addr_a[g]  = req_addr[g*AW +: AW];
        assign wdata_a[g] = req_wdata[g*DW +: DW];
    end

    // Search starts just after the last owner so every held request is reached within NREQ grants.
    always_comb begin
        logic [IW-1:0] cand;
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (int'(ptr_q) + k >= NREQ) cand = IW'(int'(ptr_q) + k - NREQ);
            else                         cand = IW'(int'(ptr_q) + k);
            if (!sel_found && req[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    assign wdog_exp = (wdog_q == CW'(WDOG - 1));

    always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
        if (m_axi_areset) state_q <= IDLE;
        else              state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        cmd_new_tx = 1'b0;
        rsp_valid  = '0;
        case (state_q)
            IDLE:  if (sel_found) state_d = ISSUE;
            ISSUE: begin
                cmd_new_tx = 1'b1;
                state_d    = WAIT;
            end
            WAIT:  if (cmd_done || wdog_exp) state_d = RESP;
            RESP: begin
                rsp_valid = gnt;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
        if (m_axi_areset) begin
            ptr_q       <= IW'(NREQ - 1);
            owner_q     <= '0;
            wdog_q      <= '0;
            gnt         <= '0;
            cmd_wr      <= 1'b0;
            cmd_waddr   <= '0;
            cmd_raddr   <= '0;
            cmd_din     <= '0;
            rsp_rdata   <= '0;
            rsp_resp    <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sel_found) begin
                        owner_q   <= sel_idx;
                        gnt       <= NREQ'(1) << sel_idx;
                        cmd_wr    <= req_wr[sel_idx];
                        cmd_waddr <= req_wr[sel_idx] ? addr_a[sel_idx] : '0;
                        cmd_raddr <= req_wr[sel_idx] ? '0 : addr_a[sel_idx];
                        cmd_din   <= req_wr[sel_idx] ? wdata_a[sel_idx] : '0;
                    end
                end
                ISSUE: wdog_q <= '0;
                WAIT: begin
                    wdog_q <= wdog_q + 1'b1;
                    // A real completion takes precedence over a watchdog expiry in the same cycle.
                    if (cmd_done) begin
                        rsp_rdata   <= cmd_wr ? '0 : cmd_dout;
                        rsp_resp    <= cmd_resp;
                        rsp_timeout <= cmd_timeout;
                    end else if (wdog_exp) begin
                        rsp_rdata   <= '0;
                        rsp_resp    <= 2'b10;
                        rsp_timeout <= 1'b1;
                    end
                end
                RESP: begin
                    ptr_q       <= owner_q;
                    gnt         <= '0;
                    cmd_wr      <= 1'b0;
                    cmd_waddr   <= '0;
                    cmd_raddr   <= '0;
                    cmd_din     <= '0;
                    rsp_rdata   <= '0;
                    rsp_resp    <= '0;
                    rsp_timeout <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axilite_m_arb.sv
// Directed bench for axilite_m_arb: a transaction table plus hand-written reset sequences.
module tb_axilite_m_arb;

    localparam int NREQ = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int WDOG = 32;

    logic               m_axi_aclk = 1'b0;
    logic               m_axi_areset;
    logic [NREQ-1:0]    req, req_wr;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    gnt, rsp_valid;
    logic [DW-1:0]      rsp_rdata;
    logic [1:0]         rsp_resp;
    logic               rsp_timeout, cmd_new_tx, cmd_wr;
    logic [AW-1:0]      cmd_waddr, cmd_raddr;
    logic [DW-1:0]      cmd_din;
    logic               cmd_done;
    logic [DW-1:0]      cmd_dout;
    logic [1:0]         cmd_resp;
    logic               cmd_timeout;

    int checks = 0;
    int errors = 0;

    always #5 m_axi_aclk = ~m_axi_aclk;

    axilite_m_arb #(.NREQ(NREQ), .AW(AW), .DW(DW), .WDOG(WDOG)) dut (
        .m_axi_aclk  (m_axi_aclk),
        .m_axi_areset(m_axi_areset),
        .req         (req),
        .req_wr      (req_wr),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .gnt         (gnt),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_resp    (rsp_resp),
        .rsp_timeout (rsp_timeout),
        .cmd_new_tx  (cmd_new_tx),
        .cmd_wr      (cmd_wr),
        .cmd_waddr   (cmd_waddr),
        .cmd_raddr   (cmd_raddr),
        .cmd_din     (cmd_din),
        .cmd_done    (cmd_done),
        .cmd_dout    (cmd_dout),
        .cmd_resp    (cmd_resp),
        .cmd_timeout (cmd_timeout)
    );

    wire any_out = (|gnt) | (|rsp_valid) | (|rsp_rdata) | (|rsp_resp) | rsp_timeout |
                   cmd_new_tx | cmd_wr | (|cmd_waddr) | (|cmd_raddr) | (|cmd_din);

    // Requester i drives addr | (i<<28) and wdata | (i<<24), so the latched values identify the owner.
    // dly = cycles from grant to cmd_done; dly = 0 means the master never completes.
    typedef struct {
        logic [3:0]  req;
        logic [3:0]  wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] dout;
        logic [1:0]  resp;
        logic        tmo;
        int          dly;
        logic [3:0]  e_gnt;
        logic        e_wr;
        logic [31:0] e_waddr;
        logic [31:0] e_raddr;
        logic [31:0] e_din;
        logic [31:0] e_rdata;
        logic [1:0]  e_resp;
        logic        e_tmo;
    } vec_t;

    vec_t tv [13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_inputs(input vec_t v);
        req    = v.req;
        req_wr = v.wr;
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i*AW +: AW]  = v.addr  | (32'(i) << 28);
            req_wdata[i*DW +: DW] = v.wdata | (32'(i) << 24);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int n;
        int noise;
        set_inputs(v);
        @(posedge m_axi_aclk); #1;
        n = 1;
        while (gnt == '0 && n < 10) begin
            @(posedge m_axi_aclk); #1;
            n++;
        end
        chk({tag, ".gnt_latency"}, 64'(n), 64'd1);
        chk({tag, ".gnt"}, 64'(gnt), 64'(v.e_gnt));
        chk({tag, ".new_tx"}, 64'(cmd_new_tx), 64'd1);
        chk({tag, ".cmd_wr"}, 64'(cmd_wr), 64'(v.e_wr));
        chk({tag, ".cmd_waddr"}, 64'(cmd_waddr), 64'(v.e_waddr));
        chk({tag, ".cmd_raddr"}, 64'(cmd_raddr), 64'(v.e_raddr));
        chk({tag, ".cmd_din"}, 64'(cmd_din), 64'(v.e_din));
        noise = 0;
        if (v.dly > 0) begin
            for (int i = 0; i < v.dly; i++) begin
                @(posedge m_axi_aclk); #1;
                if (cmd_new_tx || rsp_valid != '0) noise++;
            end
            cmd_done    = 1'b1;
            cmd_dout    = v.dout;
            cmd_resp    = v.resp;
            cmd_timeout = v.tmo;
            @(posedge m_axi_aclk); #1;
            cmd_done    = 1'b0;
            cmd_dout    = '0;
            cmd_resp    = '0;
            cmd_timeout = 1'b0;
        end else begin
            cmd_dout    = v.dout;
            cmd_resp    = v.resp;
            cmd_timeout = v.tmo;
            n = 0;
            while (rsp_valid == '0 && n < 60) begin
                @(posedge m_axi_aclk); #1;
                n++;
                if (cmd_new_tx) noise++;
            end
            chk({tag, ".wdog_cycles"}, 64'(n), 64'(WDOG + 1));
            cmd_dout    = '0;
            cmd_resp    = '0;
            cmd_timeout = 1'b0;
        end
        chk({tag, ".quiet_wait"}, 64'(noise), 64'd0);
        chk({tag, ".rsp_valid"}, 64'(rsp_valid), 64'(v.e_gnt));
        chk({tag, ".gnt_held"}, 64'(gnt), 64'(v.e_gnt));
        chk({tag, ".rsp_rdata"}, 64'(rsp_rdata), 64'(v.e_rdata));
        chk({tag, ".rsp_resp"}, 64'(rsp_resp), 64'(v.e_resp));
        chk({tag, ".rsp_timeout"}, 64'(rsp_timeout), 64'(v.e_tmo));
        @(posedge m_axi_aclk); #1;
        chk({tag, ".idle_outputs"}, 64'(any_out), 64'd0);
    endtask

    initial begin
        vec_t v;
        int pulses;

        // All four requesters held: grant order 0,1,2,3,0 from reset.
        tv[0]  = '{4'b1111, 4'b1010, 32'h40, 32'h11, 32'h100, 2'b00, 1'b0, 1,
                   4'b0001, 1'b0, 32'h0, 32'h40, 32'h0, 32'h100, 2'b00, 1'b0};
        tv[1]  = '{4'b1111, 4'b1010, 32'h40, 32'h11, 32'h200, 2'b01, 1'b0, 2,
                   4'b0010, 1'b1, 32'h1000_0040, 32'h0, 32'h0100_0011, 32'h0, 2'b01, 1'b0};
        tv[2]  = '{4'b1111, 4'b1010, 32'h40, 32'h11, 32'h300, 2'b11, 1'b0, 1,
                   4'b0100, 1'b0, 32'h0, 32'h2000_0040, 32'h0, 32'h300, 2'b11, 1'b0};
        tv[3]  = '{4'b1111, 4'b1010, 32'h40, 32'h11, 32'h400, 2'b00, 1'b0, 3,
                   4'b1000, 1'b1, 32'h3000_0040, 32'h0, 32'h0300_0011, 32'h0, 2'b00, 1'b0};
        tv[4]  = '{4'b1111, 4'b1010, 32'h40, 32'h11, 32'h500, 2'b00, 1'b0, 1,
                   4'b0001, 1'b0, 32'h0, 32'h40, 32'h0, 32'h500, 2'b00, 1'b0};
        // Single write from requester 2; read data on the bus must not leak into rsp_rdata.
        tv[5]  = '{4'b0100, 4'b0100, 32'h10, 32'hA5, 32'hDEAD, 2'b00, 1'b0, 5,
                   4'b0100, 1'b1, 32'h2000_0010, 32'h0, 32'h0200_00A5, 32'h0, 2'b00, 1'b0};
        // Single read from requester 0.
        tv[6]  = '{4'b0001, 4'b0000, 32'h4, 32'h77, 32'h5, 2'b00, 1'b0, 3,
                   4'b0001, 1'b0, 32'h0, 32'h4, 32'h0, 32'h5, 2'b00, 1'b0};
        // Two requesters held after owner 0: 1 then 3.
        tv[7]  = '{4'b1010, 4'b1000, 32'h80, 32'h33, 32'h66, 2'b00, 1'b0, 1,
                   4'b0010, 1'b0, 32'h0, 32'h1000_0080, 32'h0, 32'h66, 2'b00, 1'b0};
        tv[8]  = '{4'b1010, 4'b1000, 32'h80, 32'h33, 32'h67, 2'b00, 1'b0, 2,
                   4'b1000, 1'b1, 32'h3000_0080, 32'h0, 32'h0300_0033, 32'h0, 2'b00, 1'b0};
        // Master timeout passed through.
        tv[9]  = '{4'b0100, 4'b0000, 32'h8, 32'h0, 32'h99, 2'b10, 1'b1, 2,
                   4'b0100, 1'b0, 32'h0, 32'h2000_0008, 32'h0, 32'h99, 2'b10, 1'b1};
        // cmd_done on the watchdog expiry cycle: master values win.
        tv[10] = '{4'b0010, 4'b0000, 32'hC, 32'h0, 32'h1234, 2'b00, 1'b0, WDOG,
                   4'b0010, 1'b0, 32'h0, 32'h1000_000C, 32'h0, 32'h1234, 2'b00, 1'b0};
        // Master never completes: watchdog SLVERR.
        tv[11] = '{4'b1000, 4'b0000, 32'h20, 32'h0, 32'hBEEF, 2'b00, 1'b0, 0,
                   4'b1000, 1'b0, 32'h0, 32'h3000_0020, 32'h0, 32'h0, 2'b10, 1'b1};
        // Normal service after a watchdog expiry.
        tv[12] = '{4'b0001, 4'b0001, 32'h30, 32'h5A, 32'h42, 2'b00, 1'b0, 1,
                   4'b0001, 1'b1, 32'h30, 32'h0, 32'h5A, 32'h0, 2'b00, 1'b0};

        m_axi_areset = 1'b1;
        req          = '0;
        req_wr       = '0;
        req_addr     = '0;
        req_wdata    = '0;
        cmd_done     = 1'b0;
        cmd_dout     = '0;
        cmd_resp     = '0;
        cmd_timeout  = 1'b0;
        repeat (2) @(posedge m_axi_aclk);
        #1;
        chk("reset.outputs", 64'(any_out), 64'd0);
        m_axi_areset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            run_vec(tv[i], $sformatf("vec%0d", i));
        end

        // Reset asserted mid-WAIT: outputs clear without waiting for a clock edge.
        v = '{4'b0100, 4'b0000, 32'h60, 32'h0, 32'h0, 2'b00, 1'b0, 1,
              4'b0100, 1'b0, 32'h0, 32'h2000_0060, 32'h0, 32'h0, 2'b00, 1'b0};
        set_inputs(v);
        @(posedge m_axi_aclk); #1;
        chk("rst_mid.gnt_before", 64'(gnt), 64'b0100);
        repeat (3) @(posedge m_axi_aclk);
        #3;
        m_axi_areset = 1'b1;
        #1;
        chk("rst_mid.async_clear", 64'(any_out), 64'd0);
        v = '{4'b1010, 4'b0000, 32'h50, 32'h0, 32'h7, 2'b00, 1'b0, 1,
              4'b0010, 1'b0, 32'h0, 32'h1000_0050, 32'h0, 32'h7, 2'b00, 1'b0};
        set_inputs(v);
        pulses = 0;
        repeat (3) begin
            @(posedge m_axi_aclk); #1;
            if (rsp_valid != '0 || gnt != '0) pulses++;
        end
        chk("rst_mid.no_activity", 64'(pulses), 64'd0);
        m_axi_areset = 1'b0;
        run_vec(v, "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

endmodule
